// File: rtl/irqc_pkg.sv
// irqc_pkg: shared definitions for the interrupt controller.
//   - register word offsets (addr[4:2]) of the memory-mapped block
//   - FSM state encoding (IDLE / REQ / SERVICE)
//   - CAUSE register field positions and a packing helper
package irqc_pkg;

  localparam logic [2:0] OFS_PEND  = 3'd0;  // 0x00 R / W1C
  localparam logic [2:0] OFS_MASK  = 3'd1;  // 0x04 RW, 1 = enabled
  localparam logic [2:0] OFS_CAUSE = 3'd2;  // 0x08 RO
  localparam logic [2:0] OFS_EOI   = 3'd3;  // 0x0C WO
  localparam logic [2:0] OFS_CTRL  = 3'd4;  // 0x10 RW, bit0 = GIE

  localparam int CAUSE_VALID_BIT = 31;
  localparam int CAUSE_IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irqc_state_e;

  function automatic logic [31:0] cause_word(input logic valid,
                                             input logic [CAUSE_IDX_W-1:0] idx);
    logic [31:0] w;
    w = '0;
    w[CAUSE_VALID_BIT]   = valid;
    w[CAUSE_IDX_W-1:0]   = idx;
    return w;
  endfunction

endpackage

// File: rtl/irqc_arbiter.sv
// irqc_arbiter: combinational rotating-priority pick.
//   req   in  N_SRC  request vector
//   start in  3      index searched first; search wraps upward mod N_SRC
//   idx   out 3      winning index (0 when nothing requests)
//   valid out 1      any request present
// start=0 degenerates to fixed priority, lowest index wins.
module irqc_arbiter
  import irqc_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]       req,
  input  logic [CAUSE_IDX_W-1:0] start,
  output logic [CAUSE_IDX_W-1:0] idx,
  output logic                   valid
);

  logic [N_SRC-1:0] rot;
  int               pos;

  always_comb begin
    // rotate so that bit 0 of rot is request 'start'
    rot   = N_SRC'({req, req} >> start);
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        pos   = int'(start) + k;
        if (pos >= N_SRC) pos = pos - N_SRC;
        idx   = CAUSE_IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller.
// Captures rising edges of irq_src into PEND, arbitrates among PEND & MASK
// (gated by GIE), raises irq until the CPU enters kernel mode (pc31), then
// holds the in-service source in CAUSE until software writes EOI.
// Build option: IRQC_RR_EN selects a round-robin arbiter (search starts after
// the last serviced index); otherwise fixed priority, lowest index wins.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   rd, wr          bus read / write strobes
//   addr, wdata     bus byte address / write data
//   rdata           combinational read data, 0 when not selected or rd=0
//   irq_src         raw source levels (synchronous to clk)
//   pc31            CPU kernel-mode flag
//   irq             interrupt request to Control
module irq_controller
  import irqc_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             pc31,
  output logic             irq
);

  localparam int IW = CAUSE_IDX_W;

  irqc_state_e      state, state_nxt;
  logic [N_SRC-1:0] pend, mask, src_d;
  logic [N_SRC-1:0] rise, w1c, svc_clr, elig, cause_oh;
  logic             gie;
  logic [IW-1:0]    cause_idx, start_idx, win_idx;
  logic             win_vld, load_cause, take;
  logic             sel, wsel;
  logic [2:0]       ofs;
  logic             unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:N_SRC]};

  // ---- bus decode ----
  assign sel  = (addr[31:5] == BASE_ADDR[31:5]);
  assign ofs  = addr[4:2];
  assign wsel = wr & sel;

  // ---- edge capture / eligibility ----
  assign rise     = irq_src & ~src_d;
  assign w1c      = (wsel && ofs == OFS_PEND) ? wdata[N_SRC-1:0] : '0;
  assign elig     = gie ? (pend & mask) : '0;
  assign cause_oh = N_SRC'(1) << cause_idx;
  // the serviced source is acknowledged on the REQ->SERVICE edge
  assign svc_clr  = take ? cause_oh : '0;

`ifdef IRQC_RR_EN
  logic [IW-1:0] last_srv;
  assign start_idx = (last_srv == IW'(N_SRC - 1)) ? '0 : last_srv + 1'b1;

  always_ff @(posedge clk) begin
    if (reset)     last_srv <= '0;
    else if (take) last_srv <= cause_idx;
  end
`else
  assign start_idx = '0;
`endif

  irqc_arbiter #(.N_SRC(N_SRC)) u_arb (
    .req   (elig),
    .start (start_idx),
    .idx   (win_idx),
    .valid (win_vld)
  );

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_cause = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld && !pc31) begin
          state_nxt  = REQ;
          load_cause = 1'b1;
        end
      end
      REQ: begin
        if (pc31) begin
          state_nxt = SERVICE;
          take      = 1'b1;
        end else if (!(|(elig & cause_oh))) begin
          // request withdrawn (W1C, mask or GIE) before the CPU took it
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (wsel && ofs == OFS_EOI) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- register file ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      mask      <= '0;
      gie       <= 1'b0;
      src_d     <= '0;
      cause_idx <= '0;
    end else begin
      src_d <= irq_src;
      // a new edge wins over any clear in the same cycle
      pend  <= (pend & ~(w1c | svc_clr)) | rise;
      if (wsel && ofs == OFS_MASK) mask <= wdata[N_SRC-1:0];
      if (wsel && ofs == OFS_CTRL) gie  <= wdata[0];
      if (load_cause)              cause_idx <= win_idx;
    end
  end

  // ---- read mux ----
  always_comb begin
    rdata = '0;
    if (rd && sel) begin
      case (ofs)
        OFS_PEND:  rdata = 32'(pend);
        OFS_MASK:  rdata = 32'(mask);
        OFS_CAUSE: rdata = cause_word(state == SERVICE, cause_idx);
        OFS_CTRL:  rdata = {31'b0, gie};
        default:   rdata = '0;
      endcase
    end
  end

  assign irq = (state == REQ) & ~pc31;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios followed by randomized bus/source/pc31
// traffic, every cycle compared against a behavioural model of the controller.
module tb_irq_controller;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam logic [31:0] A_PEND  = BASE + 32'h00;
  localparam logic [31:0] A_MASK  = BASE + 32'h04;
  localparam logic [31:0] A_CAUSE = BASE + 32'h08;
  localparam logic [31:0] A_EOI   = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL  = BASE + 32'h10;
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;

  logic          clk, reset, rd, wr, pc31, irq;
  logic [31:0]   addr, wdata, rdata;
  logic [N-1:0]  irq_src;

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic [N-1:0] m_pend, m_mask, m_srcd;
  logic         m_gie;
  int           m_state, m_cause, m_last;

  irq_controller #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_src (irq_src),
    .pc31    (pc31),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    case (a[4:2])
      3'd0:    return {28'b0, m_pend};
      3'd1:    return {28'b0, m_mask};
      3'd2:    return {m_state == M_SVC, 28'b0, 3'(m_cause)};
      3'd4:    return {31'b0, m_gie};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int m_winner(input logic [N-1:0] e, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (e[j]) return j;
    end
    return 0;
  endfunction

  task automatic m_clear();
    m_pend = '0; m_mask = '0; m_srcd = '0; m_gie = 1'b0;
    m_state = M_IDLE; m_cause = 0; m_last = 0;
  endtask

  // Check outputs for the current inputs, advance one clock, advance the model.
  task automatic tick();
    logic [N-1:0] rise, e, clr, w1c, n_pend, n_mask;
    logic         n_gie, wsel;
    int           n_state, n_cause, n_last, start;
    #1;
    chk("irq", 32'(irq), 32'((m_state == M_REQ) && !pc31));
    chk("rdata", rdata, rd ? m_read(addr) : 32'h0);

`ifdef IRQC_RR_EN
    start = (m_last + 1) % N;
`else
    start = 0;
`endif
    rise    = irq_src & ~m_srcd;
    wsel    = wr && (addr[31:5] == BASE[31:5]);
    e       = m_gie ? (m_pend & m_mask) : '0;
    clr     = '0;
    n_state = m_state; n_cause = m_cause; n_last = m_last;
    if (m_state == M_IDLE) begin
      if (e != 0 && !pc31) begin
        n_state = M_REQ;
        n_cause = m_winner(e, start);
      end
    end else if (m_state == M_REQ) begin
      if (pc31) begin
        n_state = M_SVC;
        clr     = N'(1) << m_cause;
        n_last  = m_cause;
      end else if (((e >> m_cause) & N'(1)) == 0) begin
        n_state = M_IDLE;
      end
    end else begin
      if (wsel && addr[4:2] == 3'd3) n_state = M_IDLE;
    end
    w1c    = (wsel && addr[4:2] == 3'd0) ? wdata[N-1:0] : '0;
    n_pend = (m_pend & ~(w1c | clr)) | rise;
    n_mask = (wsel && addr[4:2] == 3'd1) ? wdata[N-1:0] : m_mask;
    n_gie  = (wsel && addr[4:2] == 3'd4) ? wdata[0] : m_gie;

    @(posedge clk);
    #1;
    if (reset) m_clear();
    else begin
      m_pend = n_pend; m_mask = n_mask; m_gie = n_gie; m_srcd = irq_src;
      m_state = n_state; m_cause = n_cause; m_last = n_last;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    chk(tag, rdata, exp);
    tick();
    rd = 1'b0; addr = '0;
  endtask

  task automatic wait_irq(input string tag);
    int k;
    k = 0;
    #1;
    while (irq !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    chk(tag, 32'(irq), 32'h1);
  endtask

  logic [2:0] first_idx, second_idx;

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    irq_src = '0; pc31 = 1'b0;
    m_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset state
    #1;
    chk("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_pend",  A_PEND,  32'h0);
    rd_chk("rst_mask",  A_MASK,  32'h0);
    rd_chk("rst_cause", A_CAUSE, 32'h0);
    rd_chk("rst_ctrl",  A_CTRL,  32'h0);

    // 1: latency and PEND
    bus_wr(A_CTRL, 32'h1);
    bus_wr(A_MASK, 32'h4);
    irq_src = 4'h4;
    tick();
    irq_src = 4'h0;
    #1 chk("t1_lat1", 32'(irq), 32'h0);
    tick();
    #1 chk("t1_lat2", 32'(irq), 32'h1);
    rd_chk("t1_pend", A_PEND, 32'h4);

    // 2: take, CAUSE, EOI
    pc31 = 1'b1;
    #1 chk("t2_irq", 32'(irq), 32'h0);
    tick();
    rd_chk("t2_cause", A_CAUSE, 32'h8000_0002);
    rd_chk("t2_pend",  A_PEND,  32'h0);
    bus_wr(A_EOI, 32'h0);
    rd_chk("t2_cause_eoi", A_CAUSE, 32'h0000_0002);
    pc31 = 1'b0;

    // 3: simultaneous sources 1 and 3
`ifdef IRQC_RR_EN
    first_idx = 3'd3; second_idx = 3'd1;
`else
    first_idx = 3'd1; second_idx = 3'd3;
`endif
    bus_wr(A_MASK, 32'hF);
    irq_src = 4'hA;
    tick();
    irq_src = 4'h0;
    wait_irq("t3_req1");
    pc31 = 1'b1; tick();
    rd_chk("t3_first", A_CAUSE, {1'b1, 28'b0, first_idx});
    pc31 = 1'b0;
    bus_wr(A_EOI, 32'h0);
    wait_irq("t3_req2");
    pc31 = 1'b1; tick();
    rd_chk("t3_second", A_CAUSE, {1'b1, 28'b0, second_idx});
    pc31 = 1'b0;
    bus_wr(A_EOI, 32'h0);

    // 4: withdraw request by W1C while in REQ
    irq_src = 4'h1;
    tick();
    irq_src = 4'h0;
    wait_irq("t4_req");
    bus_wr(A_PEND, 32'h1);
    tick();
    #1 chk("t4_irq", 32'(irq), 32'h0);
    rd_chk("t4_cause", A_CAUSE, 32'h0);

    // 5: set wins over W1C
    bus_wr(A_MASK, 32'h0);
    irq_src = 4'h8;
    tick();
    irq_src = 4'h0;
    tick();
    rd_chk("t5_pre", A_PEND, 32'h8);
    irq_src = 4'h8; wr = 1'b1; addr = A_PEND; wdata = 32'h8;
    tick();
    irq_src = 4'h0; wr = 1'b0; addr = '0; wdata = '0;
    rd_chk("t5_setwins", A_PEND, 32'h8);
    bus_wr(A_PEND, 32'hF);

    // 6: reset during SERVICE
    bus_wr(A_MASK, 32'h4);
    irq_src = 4'h4;
    tick();
    irq_src = 4'h0;
    wait_irq("t6_req");
    pc31 = 1'b1; tick();
    rd_chk("t6_svc", A_CAUSE, 32'h8000_0002);
    reset = 1'b1; tick(); reset = 1'b0;
    pc31 = 1'b0;
    #1 chk("t6_irq", 32'(irq), 32'h0);
    rd_chk("t6_pend",  A_PEND,  32'h0);
    rd_chk("t6_mask",  A_MASK,  32'h0);
    rd_chk("t6_ctrl",  A_CTRL,  32'h0);
    rd_chk("t6_cause", A_CAUSE, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
      if ($urandom_range(0, 5) == 0) pc31 = ~pc31;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      addr = {(($urandom_range(0, 9) == 0) ? 27'h200_0010 : BASE[31:5]),
              3'($urandom_range(0, 7)), 2'($urandom)};
      wdata = $urandom;
      if (addr[4:2] == 3'd4) wdata[0] = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0; rd = 1'b0; wr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
